mem_burst_arbiter: RTL and testbench
====================================

# mem_burst_arbiter

Shares the single 19-bit-addressed data memory between two requesters (requester 0: loader/DMA side, requester 1: processing core) and sequences each granted burst. It latches the winner's base address, length and direction, then drives one memory address per accepted beat with the matching read or write enable, honouring a memory ready handshake. The memory port is owned by this block, so requesters never drive the memory address bus directly.

## Interface
- ADDR_W, 19, memory address width
- LEN_W, 19, burst length width (beats)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester burst request; held high until matching done pulse
- req_we  in  2  per-requester direction: 1 = write burst, 0 = read burst
- base_addr0  in  ADDR_W  requester 0 start address
- base_addr1  in  ADDR_W  requester 1 start address
- len0  in  LEN_W  requester 0 beat count
- len1  in  LEN_W  requester 1 beat count
- mem_ready  in  1  memory accepts current beat this cycle
- gnt  out  2  one-hot grant, held for whole burst
- busy  out  1  burst in progress
- mem_addr  out  ADDR_W  current beat address
- mem_re  out  1  read strobe for current beat
- mem_we  out  1  write strobe for current beat
- beat  out  1  current beat accepted (mem_re|mem_we) & mem_ready
- done  out  2  one-cycle pulse to the owning requester at burst end

## Operation
- States: IDLE, LOAD, BURST, DONE.
- IDLE: if any req bit high, pick winner, set gnt, go to LOAD. Otherwise stay.
- Arbitration is round-robin: the requester not granted last wins ties. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- LOAD: latch winner's base, len and direction. Clear beat counter. If len = 0, go to DONE with no beats; else go to BURST.
- BURST:
  - mem_addr = latched base + beat counter, modulo 2^ADDR_W (wraps 0x7FFFF -> 0x00000).
  - mem_re = ~dir and mem_we = dir, asserted for the whole state.
  - On each cycle with mem_ready high, count one beat.
  - When the accepted beat is number len, go to DONE.
  - With mem_ready low, mem_addr and the strobe hold unchanged.
- DONE: pulse done[winner] for one cycle, drop gnt and busy, update last-grant pointer, go to IDLE.
- req sampling:
  - req is sampled only in IDLE.
  - Dropping req mid-burst does not abort; the burst completes and done still pulses.
  - A requester still holding req in DONE is re-arbitrated from IDLE next cycle.
- busy is high in LOAD, BURST and DONE.
- Never asserted: mem_re and mem_we together, or both gnt bits.

## Timing
- All outputs registered; reset values: gnt=0, busy=0, mem_addr=0, mem_re=0, mem_we=0, done=0; state=IDLE; counter=0; last-grant=1.
- Cycle 0: req seen in IDLE. Cycle 1: gnt/busy high (LOAD). Cycle 2: first beat presented.
- With mem_ready tied high, a len=N burst has beats in cycles 2..N+1. done pulses in cycle N+2, and the next arbitration occurs in cycle N+3.
- Minimum req-to-done latency: N+2 cycles plus one per mem_ready-low cycle.
- Reset asserted mid-burst: all outputs clear immediately (asynchronous); no done pulse; state returns to IDLE.
- len is LEN_W wide; the maximum value 2^19-1 must complete without counter overflow (counter is LEN_W bits, compared before increment).

## Configuration
- ARB_FIXED_PRIO_EN defined: requester 0 always wins when both request; last-grant pointer unused.
- Not defined: round-robin as described in Operation.

## Test plan
- Single read: req=01, base0=0x00010, len0=4, mem_ready=1 -> gnt=01 at cycle 1; mem_addr 0x10,0x11,0x12,0x13 with mem_re=1, mem_we=0; done=01 at cycle 6.
- Write with stalls: req=10, req_we=10, base1=0x00100, len1=3, mem_ready low on 2nd beat for 2 cycles -> mem_addr holds 0x101 for 3 cycles; exactly 3 beat pulses; done=10 at cycle 7.
- Wrap: base0=0x7FFFE, len0=4 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- Contention: req=11 held continuously, len0=len1=2 -> grants 01, 10, 01, 10 (round-robin). With ARB_FIXED_PRIO_EN defined -> grant stays 01 on every burst.
- Zero length: req=01, len0=0 -> gnt at cycle 1, no mem_re/mem_we, done=01 at cycle 2.
- Reset mid-burst: rst low during beat 2 of len=8 burst -> gnt, busy, mem_re, mem_addr all 0 same cycle; no done. After release, a fresh req=11 grants requester 0.

Source files
------------

// File: rtl/mem_burst_arbiter.sv
// Two-requester memory burst arbiter/sequencer with registered memory port.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_burst_arbiter #(
  parameter int ADDR_W = 19,
  parameter int LEN_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] base_addr0,
  input  logic [ADDR_W-1:0] base_addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic              mem_ready,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic              beat,
  output logic [1:0]        done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BURST, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic [1:0]         done_q, done_d;
  logic               winner_q, winner_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               dir_q, dir_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  ld_base;
  logic [LEN_W-1:0]   ld_len;
  logic               pick;
`ifndef ARB_FIXED_PRIO_EN
  logic               last_q, last_d;
`endif

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    pick = ~req[0];
`else
    // On a tie the requester not granted last time wins
    if (req == 2'b11) pick = ~last_q;
    else              pick = ~req[0];
`endif
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    mem_addr_d = mem_addr_q;
    mem_re_d   = mem_re_q;
    mem_we_d   = mem_we_q;
    done_d     = '0;
    winner_d   = winner_q;
    base_d     = base_q;
    len_d      = len_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    cnt_inc    = cnt_q + LEN_W'(1);
    ld_base    = winner_q ? base_addr1 : base_addr0;
    ld_len     = winner_q ? len1 : len0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          winner_d = pick;
          gnt_d    = pick ? 2'b10 : 2'b01;
          busy_d   = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        base_d = ld_base;
        len_d  = ld_len;
        dir_d  = req_we[winner_q];
        cnt_d  = '0;
        if (ld_len == '0) begin
          done_d  = winner_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else begin
          mem_addr_d = ld_base;
          mem_re_d   = ~req_we[winner_q];
          mem_we_d   = req_we[winner_q];
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (mem_ready) begin
          // Compare before increment so a full-scale length never overflows
          if (cnt_q == len_q - LEN_W'(1)) begin
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            done_d   = winner_q ? 2'b10 : 2'b01;
            state_d  = S_DONE;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = base_q + ADDR_W'(cnt_inc);
          end
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = winner_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      done_q     <= '0;
      winner_q   <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      winner_q   <= winner_d;
      base_q     <= base_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign done     = done_q;
  assign beat     = (mem_re_q | mem_we_q) & mem_ready;

  // dir_q is kept for completeness of the latched burst descriptor
  logic unused_dir;
  assign unused_dir = dir_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: directed scenarios plus random bursts
// compared against a transaction-level model (arbitration, address sequence, done timing).
module tb_mem_burst_arbiter;
  localparam int AW = 19;
  localparam int LW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, req_we;
  logic [AW-1:0] base_addr0, base_addr1;
  logic [LW-1:0] len0, len1;
  logic          mem_ready;
  logic [1:0]    gnt;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we, beat;
  logic [1:0]    done;

  int n_tests = 0;
  int n_fail  = 0;
  int last_gnt = 1;

  mem_burst_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we),
    .base_addr0(base_addr0), .base_addr1(base_addr1),
    .len0(len0), .len1(len1), .mem_ready(mem_ready),
    .gnt(gnt), .busy(busy), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .beat(beat), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_winner(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return (last_gnt == 1) ? 0 : 1;
`endif
  endfunction

  // Entered #1 after a rising edge with the DUT idle; leaves at the same phase, DUT idle.
  task automatic do_burst(input logic [1:0] r, input logic [1:0] we,
                          input int b0, input int b1, input int l0, input int l1,
                          input int stall_pct, input logic [31:0] stall_mask,
                          input bit drop_req, input bit keep_req, output int done_cyc);
    int w, base, len, k, iter, run_stall;
    logic dir;
    logic [1:0] exp_g;
    bit stall;
    req = r; req_we = we;
    base_addr0 = AW'(b0); base_addr1 = AW'(b1);
    len0 = LW'(l0); len1 = LW'(l1);
    w     = pick_winner(r);
    base  = (w == 0) ? b0 : b1;
    len   = (w == 0) ? l0 : l1;
    dir   = we[w];
    exp_g = (w == 0) ? 2'b01 : 2'b10;

    @(negedge clk);
    chk("c0_busy", busy, 0);
    chk("c0_gnt", gnt, 0);
    @(posedge clk); #1;
    if (drop_req) req = 2'b00;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("load_gnt", gnt, exp_g);
    chk("load_busy", busy, 1);
    chk("load_strobe", {mem_re, mem_we}, 0);
    chk("load_done", done, 0);

    k = 0; iter = 0; run_stall = 0;
    while (k < len && iter < 4 * len + 8) begin
      @(posedge clk); #1;
      stall = (iter < 32) ? stall_mask[iter] : 1'b0;
      if (!stall && run_stall < 3 && int'($urandom_range(0, 99)) < stall_pct) stall = 1'b1;
      mem_ready = !stall;
      run_stall = stall ? run_stall + 1 : 0;
      @(negedge clk);
      chk("addr", mem_addr, (base + k) % (1 << 19));
      chk("re", mem_re, !dir);
      chk("we", mem_we, dir);
      chk("beat", beat, mem_ready);
      chk("burst_gnt", gnt, exp_g);
      chk("done_early", done, 0);
      if (mem_ready) k++;
      iter++;
    end
    if (k < len) chk("burst_budget", k, len);

    @(posedge clk); #1;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done", done, exp_g);
    chk("done_busy", busy, 1);
    chk("done_strobe", {mem_re, mem_we}, 0);
    chk("done_beat", beat, 0);
    done_cyc = 2 + iter;

    @(posedge clk); #1;
    if (!keep_req) req = 2'b00;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    last_gnt = w;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    rst = 1'b0; req = '0; req_we = '0; base_addr0 = '0; base_addr1 = '0;
    len0 = '0; len1 = '0; mem_ready = 1'b0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_strobe", {mem_re, mem_we}, 0);
    chk("rst_done", done, 0);
    chk("rst_beat", beat, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single read
    do_burst(2'b01, 2'b00, 'h10, 0, 4, 0, 0, 32'h0, 0, 0, dc);
    chk("t_read_done_cyc", dc, 6);
    // Write with a 2-cycle stall on the second beat
    do_burst(2'b10, 2'b10, 0, 'h100, 0, 3, 0, 32'h6, 0, 0, dc);
    chk("t_write_done_cyc", dc, 7);
    // Address wrap
    do_burst(2'b01, 2'b00, 'h7FFFE, 0, 4, 0, 0, 32'h0, 0, 0, dc);
    chk("t_wrap_done_cyc", dc, 6);
    // Zero length
    do_burst(2'b01, 2'b00, 'h55, 0, 0, 0, 0, 32'h0, 0, 0, dc);
    chk("t_zero_done_cyc", dc, 2);
    // Contention with req held continuously
    for (int i = 0; i < 4; i++)
      do_burst(2'b11, 2'b01, 'h300, 'h400, 2, 2, 0, 32'h0, 0, (i < 3), dc);
    // Request dropped mid-burst still completes
    do_burst(2'b10, 2'b00, 0, 'h1234, 0, 5, 20, 32'h0, 1, 0, dc);

    // Reset during the second beat of an 8-beat burst
    req = 2'b01; req_we = 2'b00; base_addr0 = 'h200; len0 = 8; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_pre_addr", mem_addr, 'h201);
    #1 rst = 1'b0; req = 2'b00;
    #1;
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_re", mem_re, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", done, 0);
      chk("rst_hold_busy", busy, 0);
    end
    rst = 1'b1;
    last_gnt = 1;
    @(posedge clk); #1;
    do_burst(2'b11, 2'b00, 'h40, 'h80, 3, 3, 0, 32'h0, 0, 0, dc);

    // Random bursts
    for (int i = 0; i < 30; i++) begin
      logic [1:0] r, w;
      int b0, b1;
      r  = 2'($urandom_range(1, 3));
      w  = 2'($urandom_range(0, 3));
      b0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range('h7FFF4, 'h7FFFF)) : int'($urandom_range(0, 'h7FFFF));
      b1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range('h7FFF4, 'h7FFFF)) : int'($urandom_range(0, 'h7FFFF));
      do_burst(r, w, b0, b1, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 40)), 32'h0, bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), dc);
    end

    // One long burst crossing the top of the address space
    do_burst(2'b10, 2'b10, 0, 'h7FF80, 0, 300, 10, 32'h0, 0, 0, dc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
